// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, widths, slot states.
package sevenseg_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_OFF = '0;

    // Active-high glyphs, bit0=a .. bit6=g; b and d are lowercase.
    localparam logic [SEG_W-1:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {SLOT_GUARD, SLOT_DRIVE} slot_t;

endpackage

// File: rtl/sevenseg_scan_if.sv
// Load-side bus of the scan driver: value source drives, driver reports pending.
interface sevenseg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_en;
    logic                    load;
    logic                    pending;

    modport master (output value_in, dp_in, blank_in, lz_en, load, input pending);
    modport slave  (input value_in, dp_in, blank_in, lz_en, load, output pending);
endinterface

// File: rtl/sevenseg_decode.sv
// Combinational hex nibble to active-high seven-segment glyph.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] glyph
);
    assign glyph = HEX_GLYPH[nibble];
endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit seven-segment driver with tear-free loading,
// guard interval, blanking and leading-zero suppression.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 25000,
    parameter int GUARD          = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    sevenseg_scan_if.slave        bus,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_start
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] value;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0]      blank;
        logic                       lz;
    } disp_t;

    // Display comes out of reset fully blanked so nothing lights before the first load.
    localparam disp_t DISP_RST = '{value: '0, dp: '0, blank: '1, lz: 1'b0};

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    disp_t                 shadow, disp;
    slot_t                 slot;
    logic                  boundary, run, dark;
    logic [NUM_DIGITS-1:0] supp;
    logic [3:0]            nib;
    logic [SEG_W-1:0]      glyph, seg_n;
    logic                  dp_n;
    logic [NUM_DIGITS-1:0] an_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A load coinciding with the boundary still lets the older shadow through first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            disp        <= DISP_RST;
            bus.pending <= 1'b0;
        end else begin
            if (boundary && bus.pending)
                disp <= shadow;
            if (bus.load)
                shadow <= '{value: bus.value_in, dp: bus.dp_in,
                            blank: bus.blank_in, lz: bus.lz_en};
            bus.pending <= bus.load | (bus.pending & ~boundary);
        end
    end

    assign nib = disp.value[idx];

    sevenseg_decode u_decode (
        .nibble (nib),
        .glyph  (glyph)
    );

    always_comb begin
        slot     = (cnt < CNT_W'(GUARD)) ? SLOT_GUARD : SLOT_DRIVE;
        boundary = (cnt == CNT_LAST) && (idx == IDX_LAST);
        // Zero run from the top digit; a blanked nonzero digit still ends it.
        run  = disp.lz;
        supp = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run     = run & (disp.value[i] == 4'h0);
            supp[i] = run;
        end
        dark  = disp.blank[idx] | supp[idx];
        seg_n = SEG_OFF;
        dp_n  = 1'b0;
        an_n  = '0;
        if (slot == SLOT_DRIVE) begin
            an_n[idx] = 1'b1;
            if (!dark)
                seg_n = glyph;
            dp_n = disp.dp[idx] & ~disp.blank[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg         <= SEG_OFF ^ {SEG_W{SEG_ACTIVE_LOW}};
            dp          <= SEG_ACTIVE_LOW;
            an          <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_n ^ {SEG_W{SEG_ACTIVE_LOW}};
            dp          <= dp_n ^ SEG_ACTIVE_LOW;
            an          <= an_n ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: frame-position reference model plus vector table and corner sequences.
module tb_sevenseg_scan;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int G  = 2;
    localparam int FR = ND * RD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_start;

    sevenseg_scan_if #(.NUM_DIGITS(ND)) bus ();

    sevenseg_scan #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(G),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
    } img_t;

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic            lz;
        logic [3:0][6:0] seg;   // expected active-low segments, digit 3..0
        logic [3:0]      dpx;   // expected active-low dp per digit
    } vec_t;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   p;          // scan position (cycles since reset release)
    img_t m_disp, m_shadow;
    bit   m_pend;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (pos %0d)", nm, act, exp, p);
        end
    endtask

    task automatic model_reset();
        p        = 0;
        m_disp   = '{value: 16'h0, dp: 4'h0, blank: 4'hF, lz: 1'b0};
        m_shadow = '0;
        m_pend   = 1'b0;
    endtask

    // One clock: predict outputs from the frame position, advance, compare.
    task automatic tick(input bit ld);
        int         slot_cyc, d, v, nib;
        bit         supp, dark;
        logic [6:0] e_seg;
        logic       e_dp, e_fs;
        logic [3:0] e_an;
        bus.load = ld;
        slot_cyc = p % RD;
        d        = (p / RD) % ND;
        v        = int'(m_disp.value);
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (slot_cyc >= G) begin
            e_an = ~(4'b0001 << d);
            nib  = (v >> (4 * d)) & 15;
            supp = m_disp.lz && d > 0 && ((v >> (4 * d)) == 0);
            dark = m_disp.blank[d] || supp;
            if (!dark) e_seg = ~glyph[nib];
            if (m_disp.dp[d] && !m_disp.blank[d]) e_dp = 1'b0;
        end
        e_fs = (p % FR == FR - 1);
        @(posedge clk);
        if (e_fs && m_pend) begin
            m_disp = m_shadow;
            m_pend = 1'b0;
        end
        if (ld) begin
            m_shadow = '{value: bus.value_in, dp: bus.dp_in, blank: bus.blank_in, lz: bus.lz_en};
            m_pend   = 1'b1;
        end
        p++;
        #1;
        chk("seg", seg, e_seg);
        chk("dp", dp, e_dp);
        chk("an", an, e_an);
        chk("frame_start", frame_start, e_fs);
        chk("pending", bus.pending, m_pend);
        bus.load = 1'b0;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_seg"}, seg, 7'h7F);
        chk({nm, "_dp"}, dp, 1'b1);
        chk({nm, "_an"}, an, 4'hF);
        chk({nm, "_fs"}, frame_start, 1'b0);
        chk({nm, "_pending"}, bus.pending, 1'b0);
    endtask

    task automatic set_in(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b, input logic lz);
        bus.value_in = v;
        bus.dp_in    = d;
        bus.blank_in = b;
        bus.lz_en    = lz;
    endtask

    initial begin
        bit         got;
        int         n;
        logic [3:0] seen, ea;
        logic [31:0] r;

        tbl[0]  = '{16'h1234, 4'h0, 4'h0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
        tbl[1]  = '{16'hAAAA, 4'h0, 4'h0, 1'b0, {7'h08, 7'h08, 7'h08, 7'h08}, 4'hF};
        tbl[2]  = '{16'h0050, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
        tbl[3]  = '{16'h0000, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
        tbl[4]  = '{16'h1234, 4'b0010, 4'b0100, 1'b0, {7'h79, 7'h7F, 7'h30, 7'h19}, 4'b1101};
        tbl[5]  = '{16'h0000, 4'hF, 4'h0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'h0};
        tbl[6]  = '{16'h0000, 4'b1000, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111};
        tbl[7]  = '{16'h0F00, 4'h0, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h40, 7'h40}, 4'hF};
        tbl[8]  = '{16'hBCDE, 4'h0, 4'h0, 1'b0, {7'h03, 7'h46, 7'h21, 7'h06}, 4'hF};
        tbl[9]  = '{16'h6789, 4'h0, 4'h0, 1'b0, {7'h02, 7'h78, 7'h00, 7'h10}, 4'hF};
        tbl[10] = '{16'hF000, 4'h0, 4'h0, 1'b1, {7'h0E, 7'h40, 7'h40, 7'h40}, 4'hF};
        tbl[11] = '{16'h1234, 4'b0100, 4'b0100, 1'b0, {7'h79, 7'h7F, 7'h30, 7'h19}, 4'hF};

        set_in(16'h0, 4'h0, 4'h0, 1'b0);
        bus.load = 1'b0;
        model_reset();

        // Reset held for 5 cycles
        repeat (5) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst = 1'b0;
        model_reset();

        // Scan order and first frame_start
        set_in(16'h1234, 4'h0, 4'h0, 1'b0);
        tick(1'b1);
        n = 0; got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            tick(1'b0);
            n++;
            if (frame_start) got = 1'b1;
        end
        chk("first_fs_delay", n, 31);
        for (int j = 0; j < FR; j++) begin
            tick(1'b0);
            ea = (j % RD < G) ? 4'hF : ~(4'b0001 << (j / RD));
            chk("scan_an", an, ea);
            if (j == G) chk("scan_d0_seg", seg, 7'h19);
        end

        // Vector table: load, wait for the boundary, check every digit of the next frame
        for (int k = 0; k < 12; k++) begin
            set_in(tbl[k].value, tbl[k].dp, tbl[k].blank, tbl[k].lz);
            if (p % FR == FR - 1) tick(1'b0);
            tick(1'b1);
            chk("tv_pending", bus.pending, 1'b1);
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                tick(1'b0);
                if (frame_start) got = 1'b1;
            end
            chk("tv_frame_start", got, 1'b1);
            seen = '0;
            for (int j = 0; j < FR; j++) begin
                tick(1'b0);
                for (int d = 0; d < ND; d++) begin
                    ea = ~(4'b0001 << d);
                    if (an == ea) begin
                        seen[d] = 1'b1;
                        chk("tv_seg", seg, tbl[k].seg[d]);
                        chk("tv_dp", dp, tbl[k].dpx[d]);
                    end
                end
            end
            chk("tv_digits_seen", seen, 4'hF);
        end

        // Load on the same edge as the frame boundary
        set_in(16'h1111, 4'h0, 4'h0, 1'b0);
        if (p % FR == FR - 1) tick(1'b0);
        tick(1'b1);
        for (int w = 0; w < FR && (p % FR) != FR - 1; w++) tick(1'b0);
        set_in(16'h2222, 4'h0, 4'h0, 1'b0);
        tick(1'b1);
        chk("sim_fs", frame_start, 1'b1);
        chk("sim_pending", bus.pending, 1'b1);
        for (int j = 0; j < 2 * FR; j++) begin
            tick(1'b0);
            if (an == 4'b1110) chk("sim_d0", seg, (j < FR) ? 7'h79 : 7'h24);
            if (j == FR - 1) chk("sim_pending_clear", bus.pending, 1'b0);
        end

        // Randomized loads, including back-to-back and leading-zero-heavy values
        for (int it = 0; it < 150; it++) begin
            n = $urandom_range(0, 40);
            repeat (n) tick(1'b0);
            r = $urandom;
            bus.value_in = 16'(r >> $urandom_range(0, 16));
            bus.dp_in    = 4'($urandom);
            bus.blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bus.lz_en    = 1'($urandom);
            tick(1'b1);
        end
        repeat (2 * FR) tick(1'b0);

        // Asynchronous reset mid-frame discards a pending load
        set_in(16'h9999, 4'hF, 4'h0, 1'b0);
        tick(1'b1);
        repeat (3) tick(1'b0);
        #2 rst = 1'b1;
        #1;
        chk_reset_outs("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (2 * FR + 5) tick(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
